// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and glyph table for the seven-segment scan controller
package seven_seg_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRIVE,
    BLANK
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, segment a in bit 0 through g in bit 6
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// rtl/seven_seg_hex_decode.sv - combinational hex nibble to active-low segment decode
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment scan with shadowed registers and PWM
// Optional leading-zero suppression: SEVEN_SEG_LEADING_ZERO_BLANK_EN
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 100000,
  parameter int BLANK_CYC  = 200
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              brightness,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int MAX_CYC = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state, state_nxt;
  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              pwm_cnt;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [3:0]              sh_br;

  logic                    load_shadow;
  logic                    boundary;
  logic                    upd_now;
  logic                    anode_active;
  logic [NUM_DIGITS-1:0]   en_eff;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              cur_nibble;
  logic [6:0]              glyph;

  always_comb begin
    state_nxt   = state;
    load_shadow = 1'b0;
    boundary    = 1'b0;
    case (state)
      LOAD: begin
        load_shadow = 1'b1;
        state_nxt   = DRIVE;
      end
      DRIVE: begin
        if (slot_cnt == SLOT_LAST) state_nxt = BLANK;
      end
      BLANK: begin
        if (slot_cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          boundary  = (idx == IDX_LAST);
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // A request on the boundary cycle itself is folded straight into this load
  assign upd_now = boundary && (pending || upd_req);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zeros_above;

  always_comb begin
    lz_mask     = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_mask[i] = zeros_above && (sh_val[4*i +: 4] == 4'h0);
      if (sh_en[i] && (sh_val[4*i +: 4] != 4'h0)) zeros_above = 1'b0;
    end
  end

  assign en_eff = sh_en & ~lz_mask;
`else
  assign en_eff = sh_en;
`endif

  assign cur_nibble   = sh_val[4*idx +: 4];
  assign anode_active = (state == DRIVE) && en_eff[idx] &&
                        ((sh_br == 4'hF) || (pwm_cnt < sh_br));

  always_comb begin
    an_sel      = '1;
    an_sel[idx] = 1'b0;
  end

  seven_seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg_n  (glyph)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD;
      slot_cnt   <= '0;
      idx        <= '0;
      pwm_cnt    <= 4'd0;
      pending    <= 1'b0;
      sh_val     <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      sh_br      <= 4'd0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
    end else begin
      state    <= state_nxt;
      slot_cnt <= (state_nxt != state) ? '0 : slot_cnt + 1'b1;
      pwm_cnt  <= (state == DRIVE) ? pwm_cnt + 4'd1 : 4'd0;
      if (state == BLANK && state_nxt == DRIVE) idx <= boundary ? '0 : idx + 1'b1;
      pending  <= boundary ? 1'b0 : (pending | upd_req);
      if (load_shadow || upd_now) begin
        sh_val <= digit_val;
        sh_en  <= digit_en;
        sh_dp  <= dp_in;
        sh_br  <= brightness;
      end
      upd_ack    <= upd_now;
      frame_tick <= boundary;
      an_n       <= anode_active ? an_sel : '1;
      seg_n      <= anode_active ? glyph : SEG_BLANK;
      dp_n       <= anode_active ? ~sh_dp[idx] : 1'b1;
    end
  end

endmodule
